// File: rtl/led_panel_scanner_if.sv
// Frame-store read port and HUB75 panel pins of led_panel_scanner.
// master = scanner side, slave = frame store / panel side.
interface led_panel_scanner_if;
  logic [5:0]  row_addr;
  logic [63:0] row_data;
  logic        panel_clk;
  logic        panel_dat_top;
  logic        panel_dat_bot;
  logic        panel_lat;
  logic        panel_oe_n;
  logic [4:0]  panel_addr;

  // row_data is the word addressed by the previous cycle's row_addr.
  // The read port has no valid/ready: the scanner assumes a fixed one-cycle latency.
  modport master (
    output row_addr,
    input  row_data,
    output panel_clk,
    output panel_dat_top,
    output panel_dat_bot,
    output panel_lat,
    output panel_oe_n,
    output panel_addr
  );

  modport slave (
    input  row_addr,
    output row_data,
    input  panel_clk,
    input  panel_dat_top,
    input  panel_dat_bot,
    input  panel_lat,
    input  panel_oe_n,
    input  panel_addr
  );
endinterface

// File: rtl/led_panel_scanner.sv
// Scans a 64x64 single-colour frame onto a 1/32-scan HUB75 panel, one row pair at a time.
// Define LED_TESTPAT_EN to let test_mode substitute a checkerboard for the frame data.
module led_panel_scanner #(
  parameter int CLK_DIV = 2,
  parameter int OE_HOLD = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                test_mode,
  output logic                frame_sync,
  output logic [2:0]          dbg_state,
  led_panel_scanner_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OE_W  = (OE_HOLD > 1) ? $clog2(OE_HOLD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OE_W-1:0]  OE_LAST  = OE_W'(OE_HOLD - 1);

  typedef enum logic [2:0] {
    S_FETCH_TOP = 3'd0,
    S_FETCH_BOT = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT     = 3'd3,
    S_LATCH     = 3'd4,
    S_DISPLAY   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       row_q, row_d;
  logic [5:0]       col_q, col_d;
  logic             phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [OE_W-1:0]  oe_cnt_q, oe_cnt_d;
  logic [63:0]      top_buf_q, top_buf_d;
  logic [63:0]      bot_buf_q, bot_buf_d;
  logic [5:0]       row_addr_q, row_addr_d;
  logic             pclk_q, pclk_d;
  logic             dat_top_q, dat_top_d;
  logic             dat_bot_q, dat_bot_d;
  logic             lat_q, lat_d;
  logic             oe_n_q, oe_n_d;
  logic [4:0]       paddr_q, paddr_d;
  logic             fsync_q, fsync_d;
  logic [63:0]      load_word;
  logic [5:0]       col_dec;

  // Top row r and bottom row r+32 share parity, so one pattern word serves both.
`ifdef LED_TESTPAT_EN
  logic [63:0] pattern;
  assign pattern   = row_q[0] ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
  assign load_word = test_mode ? pattern : bus.row_data;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign load_word        = bus.row_data;
`endif

  assign col_dec = col_q - 6'd1;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    phase_d    = phase_q;
    div_d      = div_q;
    oe_cnt_d   = oe_cnt_q;
    top_buf_d  = top_buf_q;
    bot_buf_d  = bot_buf_q;
    row_addr_d = row_addr_q;
    pclk_d     = pclk_q;
    dat_top_d  = dat_top_q;
    dat_bot_d  = dat_bot_q;
    lat_d      = 1'b0;
    oe_n_d     = oe_n_q;
    paddr_d    = paddr_q;
    fsync_d    = 1'b0;
    case (state_q)
      S_FETCH_TOP: begin
        state_d    = S_FETCH_BOT;
        row_addr_d = {1'b1, row_q};
      end
      S_FETCH_BOT: begin
        state_d   = S_CAPTURE;
        top_buf_d = load_word;
      end
      S_CAPTURE: begin
        // Bottom word is still on row_data here, so column 63 is taken from it directly.
        state_d   = S_SHIFT;
        bot_buf_d = load_word;
        col_d     = 6'd63;
        phase_d   = 1'b0;
        div_d     = '0;
        pclk_d    = 1'b0;
        dat_top_d = top_buf_q[63];
        dat_bot_d = load_word[63];
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            pclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            pclk_d  = 1'b0;
            if (col_q == 6'd0) begin
              state_d = S_LATCH;
              lat_d   = 1'b1;
              paddr_d = row_q;
            end else begin
              col_d     = col_dec;
              dat_top_d = top_buf_q[col_dec];
              dat_bot_d = bot_buf_q[col_dec];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        state_d  = S_DISPLAY;
        oe_n_d   = 1'b0;
        oe_cnt_d = '0;
      end
      S_DISPLAY: begin
        if (oe_cnt_q == OE_LAST) begin
          state_d    = S_FETCH_TOP;
          oe_n_d     = 1'b1;
          row_d      = row_q + 5'd1;
          row_addr_d = {1'b0, row_q + 5'd1};
          fsync_d    = (row_q == 5'd31);
        end else begin
          oe_cnt_d = oe_cnt_q + OE_W'(1);
        end
      end
      default: state_d = S_FETCH_TOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH_TOP;
      row_q      <= '0;
      col_q      <= '0;
      phase_q    <= 1'b0;
      div_q      <= '0;
      oe_cnt_q   <= '0;
      top_buf_q  <= '0;
      bot_buf_q  <= '0;
      row_addr_q <= '0;
      pclk_q     <= 1'b0;
      dat_top_q  <= 1'b0;
      dat_bot_q  <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      paddr_q    <= '0;
      fsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
      oe_cnt_q   <= oe_cnt_d;
      top_buf_q  <= top_buf_d;
      bot_buf_q  <= bot_buf_d;
      row_addr_q <= row_addr_d;
      pclk_q     <= pclk_d;
      dat_top_q  <= dat_top_d;
      dat_bot_q  <= dat_bot_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      paddr_q    <= paddr_d;
      fsync_q    <= fsync_d;
    end
  end

  assign bus.row_addr      = row_addr_q;
  assign bus.panel_clk     = pclk_q;
  assign bus.panel_dat_top = dat_top_q;
  assign bus.panel_dat_bot = dat_bot_q;
  assign bus.panel_lat     = lat_q;
  assign bus.panel_oe_n    = oe_n_q;
  assign bus.panel_addr    = paddr_q;
  assign frame_sync        = fsync_q;
  assign dbg_state         = state_q;

endmodule
